// File: rtl/fp16_mul_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// fp16_arb_pkg
// Shared types and constants for the FP16 multiplier arbiter slice.
//   FP16_W     : width of an FP16 operand/result
//   fp16_t     : FP16 bit container (values are never interpreted here)
//   FP16_ZERO  : value driven onto idle multiplier operands
//   PERF_CNT_W : width of the optional performance counters
// No ports (package).
// -----------------------------------------------------------------------------
package fp16_arb_pkg;

    localparam int FP16_W = 16;

    typedef logic [FP16_W-1:0] fp16_t;

    localparam fp16_t FP16_ZERO = 16'h0000;

    localparam int PERF_CNT_W = 32;

endpackage

// File: rtl/fp16_mul_arbiter_if.sv
// -----------------------------------------------------------------------------
// fp16_mul_arbiter_if
// Bundles the requester, multiplier and response signals of the arbiter.
//   req_valid/req_ready/req_a/req_b : per-requester operand-pair handshake
//   mul_en/mul_a/mul_b/mul_result   : shared multiplier connection
//   rsp_valid/rsp_ready/rsp_id/rsp_data : tagged, backpressured response
// Modports:
//   slave  : arbiter view (accepts requests, drives multiplier, sends responses)
//   master : environment view (requesters, multiplier, response consumer)
// -----------------------------------------------------------------------------
interface fp16_mul_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = fp16_arb_pkg::FP16_W,
    parameter int ID_W       = $clog2(NUM_REQ)
);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_a;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_b;

    logic                          mul_en;
    logic [DATA_WIDTH-1:0]         mul_a;
    logic [DATA_WIDTH-1:0]         mul_b;
    logic [DATA_WIDTH-1:0]         mul_result;

    logic                          rsp_valid;
    logic                          rsp_ready;
    logic [ID_W-1:0]               rsp_id;
    logic [DATA_WIDTH-1:0]         rsp_data;

    modport slave (
        input  req_valid, req_a, req_b, mul_result, rsp_ready,
        output req_ready, mul_en, mul_a, mul_b, rsp_valid, rsp_id, rsp_data
    );

    modport master (
        output req_valid, req_a, req_b, mul_result, rsp_ready,
        input  req_ready, mul_en, mul_a, mul_b, rsp_valid, rsp_id, rsp_data
    );

endinterface

// File: rtl/fp16_mul_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin picker: grants the first asserted req at or after
// ptr, wrapping at N.
//   req     in  N     request vector
//   ptr     in  ID_W  highest-priority index for this cycle
//   en      in  1     allow a grant this cycle
//   gnt     out N     one-hot grant (zero when no grant)
//   gnt_idx out ID_W  index of the winner (meaningful only when any = 1)
//   any     out 1     a grant is issued
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N    = 4,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    input  logic            en,
    output logic [N-1:0]    gnt,
    output logic [ID_W-1:0] gnt_idx,
    output logic            any
);

    logic found;

    // ptr is always < N, so a single conditional subtract implements the wrap
    // even when N is not a power of two.
    function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= N) s = s - N;
        return ID_W'(s);
    endfunction

    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < N; k++) begin
            if (!found && req[wrap_idx(ptr, k)]) begin
                found   = 1'b1;
                gnt_idx = wrap_idx(ptr, k);
            end
        end
    end

    assign any = en && found;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_gnt
            assign gnt[gi] = any && (gnt_idx == ID_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/fp16_mul_arbiter.sv
// -----------------------------------------------------------------------------
// fp16_mul_arbiter
// Shares one FP16 multiplier among NUM_REQ requesters. Operand pairs are taken
// round-robin, issued to the multiplier, and the single in-flight product is
// returned tagged with its requester index over a backpressured response port.
//   clk    in  system clock, rising edge
//   reset  in  asynchronous, active-low reset
//   bus    slave modport of fp16_mul_arbiter_if (requests, multiplier, response)
// Optional feature, macro FP16_MUL_ARB_PERF_EN:
//   perf_issue_cnt out 32  wrapping count of mul_en cycles
//   perf_stall_cnt out 32  wrapping count of cycles with a pending request
//                          that could not be issued
// -----------------------------------------------------------------------------
module fp16_mul_arbiter
    import fp16_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = FP16_W,
    parameter int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  reset,
    fp16_mul_arbiter_if.slave     bus
`ifdef FP16_MUL_ARB_PERF_EN
    ,
    output logic [PERF_CNT_W-1:0] perf_issue_cnt,
    output logic [PERF_CNT_W-1:0] perf_stall_cnt
`endif
);

    logic            inflight_reg,    inflight_next;
    logic [ID_W-1:0] inflight_id_reg, inflight_id_next;
    logic            rsp_valid_reg,   rsp_valid_next;
    logic [ID_W-1:0] rsp_id_reg,      rsp_id_next;
    fp16_t           rsp_data_reg,    rsp_data_next;
    logic [ID_W-1:0] prio_ptr_reg,    prio_ptr_next;

    logic               capture;
    logic               issue_ok;
    logic               issue;
    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_idx;
    fp16_t              op_a [NUM_REQ];
    fp16_t              op_b [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ops
            assign op_a[gi] = bus.req_a[gi*DATA_WIDTH +: DATA_WIDTH];
            assign op_b[gi] = bus.req_b[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // The multiplier result moves into the response register whenever that
    // register is empty or being drained this cycle; doing so frees the
    // multiplier for a new issue in the same cycle.
    assign capture  = inflight_reg && (!rsp_valid_reg || bus.rsp_ready);
    assign issue_ok = !inflight_reg || capture;

    // Grants are also suppressed while reset is asserted (reset low) so that
    // every output reads zero during reset, not just the registered ones.
    rr_arbiter #(
        .N    (NUM_REQ),
        .ID_W (ID_W)
    ) u_rr (
        .req     (bus.req_valid),
        .ptr     (prio_ptr_reg),
        .en      (issue_ok && reset),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (issue)
    );

    assign bus.req_ready = gnt;
    assign bus.mul_en    = issue;
    assign bus.mul_a     = issue ? op_a[gnt_idx] : FP16_ZERO;
    assign bus.mul_b     = issue ? op_b[gnt_idx] : FP16_ZERO;
    assign bus.rsp_valid = rsp_valid_reg;
    assign bus.rsp_id    = rsp_id_reg;
    assign bus.rsp_data  = rsp_data_reg;

    always_comb begin
        inflight_next    = inflight_reg;
        inflight_id_next = inflight_id_reg;
        rsp_valid_next   = rsp_valid_reg;
        rsp_id_next      = rsp_id_reg;
        rsp_data_next    = rsp_data_reg;
        prio_ptr_next    = prio_ptr_reg;

        if (capture) begin
            rsp_valid_next = 1'b1;
            rsp_id_next    = inflight_id_reg;
            rsp_data_next  = bus.mul_result;
            inflight_next  = 1'b0;
        end else if (rsp_valid_reg && bus.rsp_ready) begin
            rsp_valid_next = 1'b0;
        end

        // A same-cycle issue overrides the clear from capture.
        if (issue) begin
            inflight_next    = 1'b1;
            inflight_id_next = gnt_idx;
            prio_ptr_next    = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inflight_reg    <= 1'b0;
            inflight_id_reg <= '0;
            rsp_valid_reg   <= 1'b0;
            rsp_id_reg      <= '0;
            rsp_data_reg    <= FP16_ZERO;
            prio_ptr_reg    <= '0;
        end else begin
            inflight_reg    <= inflight_next;
            inflight_id_reg <= inflight_id_next;
            rsp_valid_reg   <= rsp_valid_next;
            rsp_id_reg      <= rsp_id_next;
            rsp_data_reg    <= rsp_data_next;
            prio_ptr_reg    <= prio_ptr_next;
        end
    end

`ifdef FP16_MUL_ARB_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_issue_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (issue) begin
                perf_issue_cnt <= perf_issue_cnt + PERF_CNT_W'(1);
            end
            if (|bus.req_valid && !issue_ok) begin
                perf_stall_cnt <= perf_stall_cnt + PERF_CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_fp16_mul_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fp16_mul_arbiter
// Self-checking bench for fp16_mul_arbiter with a registered multiplier model.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge. Honors FP16_MUL_ARB_PERF_EN when defined.
// -----------------------------------------------------------------------------
module tb_fp16_mul_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    fp16_mul_arbiter_if #(.NUM_REQ(4)) bus ();

`ifdef FP16_MUL_ARB_PERF_EN
    logic [31:0] perf_issue_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    fp16_mul_arbiter #(.NUM_REQ(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus)
`ifdef FP16_MUL_ARB_PERF_EN
        ,
        .perf_issue_cnt (perf_issue_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    // Multiplier stand-in: products of the operand pairs used below,
    // worked out by hand. Anything else returns a quiet NaN.
    function automatic logic [15:0] fp_mul_model(input logic [15:0] a, input logic [15:0] b);
        case ({a, b})
            32'h4000_3E00: return 16'h4200; // 2.0 * 1.5 = 3.0
            32'h0000_3C00: return 16'h0000; // 0.0 * 1.0 = 0.0
            32'h4000_4000: return 16'h4400; // 2.0 * 2.0 = 4.0
            32'h3800_4000: return 16'h3C00; // 0.5 * 2.0 = 1.0
            32'h3C00_4000: return 16'h4000; // 1.0 * 2.0 = 2.0
            32'h4200_4000: return 16'h4600; // 3.0 * 2.0 = 6.0
            default:       return 16'h7E00;
        endcase
    endfunction

    always @(posedge clk) begin
        if (bus.mul_en) bus.mul_result <= fp_mul_model(bus.mul_a, bus.mul_b);
    end

    typedef struct {
        int          id;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] p;
    } vec_t;

    vec_t        vecs [4];
    logic [15:0] ra [4];
    logic [15:0] rp [4];
    int          n_cmp  = 0;
    int          n_fail = 0;
    int          issues;
    logic [3:0]  gnt_s;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic set_ops(input int id, input logic [15:0] a, input logic [15:0] b);
        bus.req_a[id*16 +: 16] = a;
        bus.req_b[id*16 +: 16] = b;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req_ready"}, 32'(bus.req_ready), 0);
        chk({tag, "_mul_en"},    32'(bus.mul_en),    0);
        chk({tag, "_mul_a"},     32'(bus.mul_a),     0);
        chk({tag, "_mul_b"},     32'(bus.mul_b),     0);
        chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 0);
        chk({tag, "_rsp_id"},    32'(bus.rsp_id),    0);
        chk({tag, "_rsp_data"},  32'(bus.rsp_data),  0);
    endtask

    initial begin
        vecs[0] = '{id: 0, a: 16'h4000, b: 16'h3E00, p: 16'h4200};
        vecs[1] = '{id: 2, a: 16'h0000, b: 16'h3C00, p: 16'h0000};
        vecs[2] = '{id: 1, a: 16'h4000, b: 16'h4000, p: 16'h4400};
        vecs[3] = '{id: 3, a: 16'h3800, b: 16'h4000, p: 16'h3C00};
        ra = '{16'h3C00, 16'h4000, 16'h4200, 16'h3800};
        rp = '{16'h4000, 16'h4400, 16'h4600, 16'h3C00};

        // Reset with every requester asserting: nothing may be granted.
        bus.req_valid = 4'hF;
        bus.req_a     = 64'h1111_2222_3333_4444;
        bus.req_b     = 64'h5555_6666_7777_8888;
        bus.rsp_ready = 1'b1;
        #2;
        chk_all_zero("reset");
        bus.req_valid = 4'h0;
        next_cycle();
        reset = 1'b1;
        next_cycle();

        // Single transactions: grant in T, response in T+2.
        for (int v = 0; v < 4; v++) begin
            set_ops(vecs[v].id, vecs[v].a, vecs[v].b);
            bus.req_valid = 4'(1 << vecs[v].id);
            @(negedge clk);
            chk("single_ready", 32'(bus.req_ready), 32'(1 << vecs[v].id));
            chk("single_mul_en", 32'(bus.mul_en), 1);
            chk("single_mul_a", 32'(bus.mul_a), 32'(vecs[v].a));
            chk("single_mul_b", 32'(bus.mul_b), 32'(vecs[v].b));
            next_cycle();
            bus.req_valid = 4'h0;
            @(negedge clk);
            chk("single_t1_rsp_valid", 32'(bus.rsp_valid), 0);
            chk("single_t1_mul_en", 32'(bus.mul_en), 0);
            next_cycle();
            @(negedge clk);
            chk("single_rsp_valid", 32'(bus.rsp_valid), 1);
            chk("single_rsp_id", 32'(bus.rsp_id), 32'(vecs[v].id));
            chk("single_rsp_data", 32'(bus.rsp_data), 32'(vecs[v].p));
            $display("txn single id=%0d a=%h b=%h rsp_id=%0d rsp_data=%h", vecs[v].id,
                     vecs[v].a, vecs[v].b, bus.rsp_id, bus.rsp_data);
            next_cycle();
            @(negedge clk);
            chk("single_drained", 32'(bus.rsp_valid), 0);
            next_cycle();
        end

        // Round robin: all four valid, pointer starts at 0.
        for (int i = 0; i < 4; i++) set_ops(i, ra[i], 16'h4000);
        bus.req_valid = 4'hF;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c < 5) begin
                chk("rr_grant", 32'(bus.req_ready), 32'(1 << (c % 4)));
                chk("rr_mul_en", 32'(bus.mul_en), 1);
            end else begin
                chk("rr_idle_mul_en", 32'(bus.mul_en), 0);
            end
            if (c >= 2) begin
                chk("rr_rsp_valid", 32'(bus.rsp_valid), 1);
                chk("rr_rsp_id", 32'(bus.rsp_id), 32'(c - 2));
                chk("rr_rsp_data", 32'(bus.rsp_data), 32'(rp[c-2]));
                $display("txn rr cycle=%0d rsp_id=%0d rsp_data=%h", c, bus.rsp_id, bus.rsp_data);
            end
            next_cycle();
            if (c == 4) bus.req_valid = 4'h0;
        end
        @(negedge clk);
        chk("rr_last_rsp_id", 32'(bus.rsp_id), 0);
        chk("rr_last_rsp_data", 32'(bus.rsp_data), 32'h4000);
        next_cycle();

        // Backpressure: pointer is 1, requesters 0..2 pending, consumer stalled.
        bus.rsp_ready = 1'b0;
        bus.req_valid = 4'b0111;
        issues = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            gnt_s = bus.req_ready;
            if (bus.mul_en) issues++;
            if (c == 0) chk("bp_grant0", 32'(gnt_s), 32'b0010);
            if (c == 1) chk("bp_grant1", 32'(gnt_s), 32'b0100);
            if (c >= 2) begin
                chk("bp_stall_mul_en", 32'(bus.mul_en), 0);
                chk("bp_hold_rsp_data", 32'(bus.rsp_data), 32'h4400);
                chk("bp_hold_rsp_id", 32'(bus.rsp_id), 1);
            end
            next_cycle();
            bus.req_valid = bus.req_valid & ~gnt_s;
        end
        chk("bp_issue_count", 32'(issues), 2);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_resume_mul_en", 32'(bus.mul_en), 1);
        chk("bp_resume_grant", 32'(bus.req_ready), 32'b0001);
        chk("bp_resume_rsp_id", 32'(bus.rsp_id), 1);
        next_cycle();
        bus.req_valid = 4'h0;
        @(negedge clk);
        chk("bp_rsp2_id", 32'(bus.rsp_id), 2);
        chk("bp_rsp2_data", 32'(bus.rsp_data), 32'h4600);
        next_cycle();
        @(negedge clk);
        chk("bp_rsp0_id", 32'(bus.rsp_id), 0);
        chk("bp_rsp0_data", 32'(bus.rsp_data), 32'h4000);
        $display("txn backpressure issues_while_stalled=%0d", issues);
        next_cycle();
        @(negedge clk);
        chk("bp_drained", 32'(bus.rsp_valid), 0);
        next_cycle();

        // Reset while a result is in flight and another is buffered.
        bus.rsp_ready = 1'b0;
        bus.req_valid = 4'b0011;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            gnt_s = bus.req_ready;
            next_cycle();
            bus.req_valid = bus.req_valid & ~gnt_s;
        end
        chk("pre_reset_rsp_valid", 32'(bus.rsp_valid), 1);
        bus.req_valid = 4'b1010;
        reset = 1'b0;
        #1;
        chk_all_zero("midreset");
        next_cycle();
        reset = 1'b1;
        @(negedge clk);
        chk("post_reset_grant", 32'(bus.req_ready), 32'b0010);
        chk("post_reset_mul_a", 32'(bus.mul_a), 32'(ra[1]));
        chk("post_reset_rsp_valid", 32'(bus.rsp_valid), 0);
        next_cycle();
        bus.req_valid = 4'b1000;
        @(negedge clk);
        chk("post_reset_grant2", 32'(bus.req_ready), 32'b1000);
        $display("txn reset_recovery grants=1,3");
        next_cycle();
        bus.req_valid = 4'h0;
        bus.rsp_ready = 1'b1;
        repeat (4) next_cycle();

        // Issue/stall accounting: 10 issues, 3 stalled cycles.
        reset = 1'b0;
        #2;
        reset = 1'b1;
        bus.rsp_ready = 1'b0;
        set_ops(0, 16'h3C00, 16'h4000);
        bus.req_valid = 4'b0001;
        issues = 0;
        for (int c = 0; c < 13; c++) begin
            if (c == 5) bus.rsp_ready = 1'b1;
            @(negedge clk);
            if (bus.mul_en) issues++;
            next_cycle();
        end
        bus.req_valid = 4'h0;
        chk("perf_seq_issues", 32'(issues), 10);
`ifdef FP16_MUL_ARB_PERF_EN
        @(negedge clk);
        chk("perf_issue_cnt", perf_issue_cnt, 10);
        chk("perf_stall_cnt", perf_stall_cnt, 3);
`endif
        $display("txn perf_seq issues=%0d", issues);
        repeat (3) next_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fp16_mul_arbiter.md
# fp16_mul_arbiter

Round-robin arbiter and sequencer sharing one FP16 multiplier among NUM_REQ requesters. Accepts operand pairs over per-requester valid/ready, drives the multiplier's enable and operands, and tracks the single in-flight operation. Returns each product tagged with its requester ID over a backpressured response port. Sits between the systolic-array PE row controllers and the shared multiplier instance.

## Interface
- NUM_REQ, 4: number of requesters; legal range 2 to 16.
- DATA_WIDTH, 16: FP16 operand and result width. Fixed at 16.
- ID_W, $clog2(NUM_REQ): width of the requester tag.
- clk  in  1  system clock. All state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester operand-pair valid.
- req_ready  out  NUM_REQ  per-requester accept. One-hot or zero.
- req_a  in  NUM_REQ*DATA_WIDTH  flattened operand A. Requester i uses bits [i*16 +: 16].
- req_b  in  NUM_REQ*DATA_WIDTH  flattened operand B, same packing as req_a.
- mul_en  out  1  multiplier enable. High for exactly one cycle per issued operation.
- mul_a  out  DATA_WIDTH  multiplier operand A. Equals the granted req_a, or 0 when idle.
- mul_b  out  DATA_WIDTH  multiplier operand B. Equals the granted req_b, or 0 when idle.
- mul_result  in  DATA_WIDTH  multiplier registered output. Valid the cycle after mul_en and held until the next mul_en.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  ID_W  index of the requester that owns rsp_data.
- rsp_data  out  DATA_WIDTH  FP16 product.

## Operation
- Handshakes:
  - A request transfers when req_valid[i] && req_ready[i].
  - A response transfers when rsp_valid && rsp_ready.
- State:
  - inflight (1 bit): an issued result is waiting in the multiplier.
  - inflight_id (ID_W bits): owner of that result.
  - Response register: rsp_valid, rsp_id, rsp_data.
  - prio_ptr (ID_W bits): round-robin pointer.
- capture = inflight && (!rsp_valid || rsp_ready).
  - On capture, the response register loads {inflight_id, mul_result}.
  - rsp_valid is then set for the next cycle.
- issue_ok = !inflight || capture.
- When issue_ok holds and any req_valid is high:
  - Grant the first valid requester, scanning from prio_ptr upward with wrap-around.
  - Assert req_ready for the grantee and mul_en.
  - Drive mul_a and mul_b from the grantee's operands.
  - Set inflight and inflight_id <= grantee.
  - Set prio_ptr <= grantee + 1, wrapping at NUM_REQ.
- If no issue occurs, inflight clears on capture.
- rsp_valid clears on a response transfer unless a capture happens in the same cycle.
- A capture and a drain in the same cycle pass through with no bubble.
- req_ready depends only on req_valid, internal state and rsp_ready. A requester may hold req_valid high indefinitely.
- Non-granted requesters keep their operands. Nothing is dropped.
- The block does not inspect or modify FP values. Arithmetic semantics, including zero handling, belong to the multiplier.

## Timing
- Reset values:
  - req_ready = 0, mul_en = 0, mul_a = 0, mul_b = 0.
  - rsp_valid = 0, rsp_id = 0, rsp_data = 0.
  - inflight = 0, prio_ptr = 0 (requester 0 has highest priority).
- Latency: a request accepted in cycle T gives rsp_valid = 1 in cycle T+2, provided the response register was free or draining in cycle T+1.
- Throughput: one operation per cycle while rsp_ready stays high.
- Backpressure:
  - With rsp_ready low and the response register full, the result stays in the multiplier.
  - inflight stays 1 and issue stops.
  - The next issue happens in the cycle the held result is captured.
- At most one operation is ever in flight.
- Reset mid-operation: in-flight and buffered results are discarded, and the pointer returns to 0.

## Configuration
- FP16_MUL_ARB_PERF_EN defined: adds two 32-bit output ports, both wrapping and both cleared by reset.
  - perf_issue_cnt: increments on every mul_en.
  - perf_stall_cnt: increments on every cycle where |req_valid && !issue_ok.
- FP16_MUL_ARB_PERF_EN undefined: those ports and counters do not exist, and the rest of the behaviour is identical.

## Structure
- fp16_arb_pkg:
  - FP16_W = 16.
  - typedef logic [15:0] fp16_t.
  - FP16_ZERO = 16'h0000.
  - Perf counter width PERF_CNT_W = 32.
- Sub-module rr_arbiter, parameterised on N:
  - Inputs: req[N], ptr, en.
  - Outputs: one-hot gnt[N], gnt_idx, any.
- Pointer update and the response register stay in fp16_mul_arbiter.

## Test plan
- Single request: req0 with a = 0x4000 (2.0) and b = 0x3E00 (1.5), with a bench multiplier model.
  - Expect mul_en for 1 cycle.
  - Two cycles after acceptance: rsp_valid = 1, rsp_id = 0, rsp_data = 0x4200.
- All 4 requesters valid continuously, rsp_ready = 1.
  - Grants go 0,1,2,3,0 on consecutive cycles.
  - Responses are back-to-back with matching rsp_id.
- Backpressure: rsp_ready = 0 for 5 cycles while 3 requests are pending.
  - Exactly 2 issues occur.
  - rsp_data stays stable and mul_en stays low.
  - Issue resumes in the cycle rsp_ready rises.
- Zero operand: req2 with a = 0x0000 and b = 0x3C00.
  - Expect rsp_id = 2, rsp_data = 0x0000.
- Reset asserted low while inflight = 1 and rsp_valid = 1.
  - All outputs read 0 immediately.
  - After release, req1 and req3 both valid: req1 is granted first.
- With FP16_MUL_ARB_PERF_EN defined: 10 issues and 3 stall cycles.
  - Expect perf_issue_cnt = 10 and perf_stall_cnt = 3.
